// File: rtl/demux32bit_1x4_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux32bit_1x4_buf_pkg
// Shared constants and helpers for the buffered 1-to-4 word distributor.
//   WIDTH_DEF / DEPTH_DEF / PTR_W_DEF : default word width, FIFO depth and
//                                       pointer width
//   NUM_CH                            : number of output channels
//   ch_e                              : channel index CH0..CH3 = 2'd0..2'd3
//   ch_onehot()                       : 2-to-4 one-hot channel decode
// -----------------------------------------------------------------------------
package demux32bit_1x4_buf_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 2;
   localparam int PTR_W_DEF = 1;
   localparam int NUM_CH    = 4;

   typedef enum logic [1:0] {
      CH0 = 2'd0,
      CH1 = 2'd1,
      CH2 = 2'd2,
      CH3 = 2'd3
   } ch_e;

   function automatic logic [NUM_CH-1:0] ch_onehot(input ch_e ch);
      logic [NUM_CH-1:0] v;
      v = '0;
      case (ch)
         CH0:     v = 4'b0001;
         CH1:     v = 4'b0010;
         CH2:     v = 4'b0100;
         CH3:     v = 4'b1000;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/demux32bit_1x4_buf_if.sv
// -----------------------------------------------------------------------------
// demux32bit_1x4_buf_if
// Bundles the producer side and the four consumer sides of the distributor.
//   in_valid / in_ready / in_data : producer handshake and word
//   S1, S0                        : channel select, channel = {S1,S0}
//   out_valid / out_ready         : per-channel consumer handshake (bit i)
//   OUT0..OUT3                    : head word of each channel
//   occ                           : per-channel occupancy, PTR_W+1 bits each
// Modports: master = producer/consumers (test environment), slave = design.
// -----------------------------------------------------------------------------
interface demux32bit_1x4_buf_if
   import demux32bit_1x4_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int PTR_W = PTR_W_DEF
);

   logic                          in_valid;
   logic                          in_ready;
   logic [WIDTH-1:0]              in_data;
   logic                          S0;
   logic                          S1;
   logic [NUM_CH-1:0]             out_valid;
   logic [NUM_CH-1:0]             out_ready;
   logic [WIDTH-1:0]              OUT0;
   logic [WIDTH-1:0]              OUT1;
   logic [WIDTH-1:0]              OUT2;
   logic [WIDTH-1:0]              OUT3;
   logic [NUM_CH*(PTR_W+1)-1:0]   occ;

   modport master (
      output in_valid, in_data, S0, S1, out_ready,
      input  in_ready, out_valid, OUT0, OUT1, OUT2, OUT3, occ
   );

   modport slave (
      input  in_valid, in_data, S0, S1, out_ready,
      output in_ready, out_valid, OUT0, OUT1, OUT2, OUT3, occ
   );

endinterface

// File: rtl/demux32bit_1x4_buf_fifo.sv
// -----------------------------------------------------------------------------
// fifo32bit_2deep
// One output channel: small circular FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full)
//   i_data     : incoming word
//   i_pop      : consumer takes the head word (ignored when empty)
//   o_full     : count == DEPTH
//   o_valid    : count != 0
//   o_head     : head word; holds its last value once the FIFO drains
//   o_count    : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fifo32bit_2deep
   import demux32bit_1x4_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = PTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  logic [WIDTH-1:0]   i_data,
   input  logic               i_pop,
   output logic               o_full,
   output logic               o_valid,
   output logic [WIDTH-1:0]   o_head,
   output logic [PTR_W:0]     o_count
);

   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_head_nxt;

   // Full/empty come from the count so that equal pointers are never ambiguous.
   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_push       = i_push & ~w_full;
   assign w_pop        = i_pop & ~w_empty;
   assign w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // The head register tracks the word that will be at the front after this
   // edge; when the FIFO drains it simply keeps the last word it showed.
   always_comb begin
      w_head_nxt = r_head;
      if (w_pop) begin
         if (r_count > CNT_ONE) begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
         end else if (w_push) begin
            // Single entry leaves as the new word arrives.
            w_head_nxt = i_data;
         end
      end else if (w_push && w_empty) begin
         w_head_nxt = i_data;
      end
   end

   // NOTE: non-blocking assignments for all clocked state so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         r_count <= w_count_nxt;
         r_head  <= w_head_nxt;
      end
   end

   // NOTE: the storage array is not reset; an entry is only ever read after it
   // has been written, because reads are gated by the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_full  = w_full;
   assign o_valid = ~w_empty;
   assign o_head  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/demux32bit_1x4_buf.sv
// -----------------------------------------------------------------------------
// demux32bit_1x4_buf
// Buffered 1-to-4 distributor: one producer word per cycle is steered by
// {S1,S0} into that channel's FIFO; each consumer drains its own FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux32bit_1x4_buf_if.slave (producer handshake, select,
//                consumer handshakes, head words, occupancy)
// in_ready depends only on the select and the registered full flags, so there
// is no combinational path from any out_ready to in_ready.
// -----------------------------------------------------------------------------
module demux32bit_1x4_buf
   import demux32bit_1x4_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = PTR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux32bit_1x4_buf_if.slave  bus
);

   localparam int CNT_W = PTR_W + 1;

   logic [1:0]              w_sel;
   logic                    w_in_ready;
   logic [NUM_CH-1:0]       w_push;
   logic [NUM_CH-1:0]       w_pop;
   logic [NUM_CH-1:0]       w_full;
   logic [NUM_CH-1:0]       w_valid;
   logic [WIDTH-1:0]        w_head  [NUM_CH];
   logic [CNT_W-1:0]        w_count [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] w_occ;

   assign w_sel      = {bus.S1, bus.S0};
   // A full channel refuses even if it is popping this same cycle.
   assign w_in_ready = ~w_full[w_sel];
   assign w_push     = ch_onehot(ch_e'(w_sel)) & {NUM_CH{bus.in_valid & w_in_ready}};
   assign w_pop      = w_valid & bus.out_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fifo32bit_2deep #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .PTR_W (PTR_W)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_push[g]),
         .i_data  (bus.in_data),
         .i_pop   (w_pop[g]),
         .o_full  (w_full[g]),
         .o_valid (w_valid[g]),
         .o_head  (w_head[g]),
         .o_count (w_count[g])
      );
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_occ[i*CNT_W +: CNT_W] = w_count[i];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_valid;
   assign bus.OUT0      = w_head[0];
   assign bus.OUT1      = w_head[1];
   assign bus.OUT2      = w_head[2];
   assign bus.OUT3      = w_head[3];
   assign bus.occ       = w_occ;

endmodule

// File: tb/tb_demux32bit_1x4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux32bit_1x4_buf
// Directed bench for demux32bit_1x4_buf: reset/idle, single steer,
// backpressure, in-order drain with pointer wrap, concurrent push/pop and
// asynchronous reset mid-stream. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_demux32bit_1x4_buf;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   demux32bit_1x4_buf_if bus ();

   demux32bit_1x4_buf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        push;
      logic [31:0] data;
      logic        pop;
   } step_t;

   localparam logic [31:0] A1 = 32'hA1A1_0001;
   localparam logic [31:0] A2 = 32'hA2A2_0002;
   localparam logic [31:0] A3 = 32'hA3A3_0003;
   localparam logic [31:0] B1 = 32'hB1B1_0011;
   localparam logic [31:0] B2 = 32'hB2B2_0012;
   localparam logic [31:0] B3 = 32'hB3B3_0013;
   localparam logic [31:0] B4 = 32'hB4B4_0014;
   localparam logic [31:0] C1 = 32'hC1C1_0021;
   localparam logic [31:0] C2 = 32'hC2C2_0022;
   localparam logic [31:0] D1 = 32'hD1D1_0031;
   localparam logic [31:0] E1 = 32'hE1E1_0041;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [1:0] sel, input logic [31:0] data,
                        input logic [3:0] rdy);
      bus.in_valid  = vld;
      {bus.S1, bus.S0} = sel;
      bus.in_data   = data;
      bus.out_ready = rdy;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      step_t       steps [8];
      logic [31:0] exp_seq [6];
      int          k;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 4'b0000);

      // ---------------- reset then idle ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_out_valid", {28'h0, bus.out_valid}, 32'h0);
      check("rst_occ", {24'h0, bus.occ}, 32'h0);
      check("rst_out0", bus.OUT0, 32'h0);
      check("rst_out1", bus.OUT1, 32'h0);
      check("rst_out2", bus.OUT2, 32'h0);
      check("rst_out3", bus.OUT3, 32'h0);
      for (int s = 0; s < 4; s++) begin
         {bus.S1, bus.S0} = 2'(s);
         #1;
         check($sformatf("rst_in_ready_sel%0d", s), {31'h0, bus.in_ready}, 32'h1);
      end

      // ---------------- single steer ----------------
      drive(1'b1, 2'b10, 32'hDEADBEEF, 4'b0000);
      tick();
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("steer_out_valid", {28'h0, bus.out_valid}, 32'h4);
      check("steer_out2", bus.OUT2, 32'hDEADBEEF);
      check("steer_occ", {24'h0, bus.occ}, 32'h10);
      check("steer_out0", bus.OUT0, 32'h0);

      // ---------------- fill / backpressure on ch1 ----------------
      drive(1'b1, 2'b01, A1, 4'b0000);
      tick();
      drive(1'b1, 2'b01, A2, 4'b0000);
      tick();
      drive(1'b1, 2'b01, A3, 4'b0000);
      #1;
      check("full_in_ready_ch1", {31'h0, bus.in_ready}, 32'h0);
      {bus.S1, bus.S0} = 2'b00;
      #1;
      check("full_in_ready_ch0", {31'h0, bus.in_ready}, 32'h1);
      {bus.S1, bus.S0} = 2'b01;
      tick();
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("full_occ", {24'h0, bus.occ}, 32'h18);
      check("full_out1_head", bus.OUT1, A1);
      check("full_out_valid", {28'h0, bus.out_valid}, 32'h6);

      // ---------------- drain / order / wrap on ch1 ----------------
      steps[0] = '{1'b0, 32'h0, 1'b1};
      steps[1] = '{1'b0, 32'h0, 1'b1};
      steps[2] = '{1'b1, B1,    1'b0};
      steps[3] = '{1'b1, B2,    1'b1};
      steps[4] = '{1'b1, B3,    1'b1};
      steps[5] = '{1'b1, B4,    1'b0};
      steps[6] = '{1'b0, 32'h0, 1'b1};
      steps[7] = '{1'b0, 32'h0, 1'b1};
      exp_seq  = '{A1, A2, B1, B2, B3, B4};
      k = 0;
      for (int i = 0; i < 8; i++) begin
         drive(steps[i].push, 2'b01, steps[i].data, {2'b00, steps[i].pop, 1'b0});
         if (steps[i].pop) begin
            #1;
            check($sformatf("drain_valid_%0d", i), {31'h0, bus.out_valid[1]}, 32'h1);
            check($sformatf("drain_word_%0d", k), bus.OUT1, exp_seq[k]);
            k++;
         end
         tick();
      end
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("drain_empty_valid", {31'h0, bus.out_valid[1]}, 32'h0);
      check("drain_hold_last", bus.OUT1, B4);
      check("drain_occ", {24'h0, bus.occ}, 32'h10);

      // ---------------- concurrent push / pop ----------------
      drive(1'b1, 2'b11, C1, 4'b0000);
      tick();
      drive(1'b1, 2'b00, D1, 4'b0000);
      tick();
      check("conc_pre_occ", {24'h0, bus.occ}, 32'h51);
      drive(1'b1, 2'b11, C2, 4'b1001);
      #1;
      check("conc_in_ready", {31'h0, bus.in_ready}, 32'h1);
      tick();
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("conc_out3", bus.OUT3, C2);
      check("conc_occ", {24'h0, bus.occ}, 32'h50);
      check("conc_out_valid", {28'h0, bus.out_valid}, 32'hC);
      check("conc_out0_hold", bus.OUT0, D1);

      // ---------------- async reset mid-stream ----------------
      drive(1'b1, 2'b00, E1, 4'b0000);
      tick();
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("arst_pre_valid", {28'h0, bus.out_valid}, 32'hD);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {28'h0, bus.out_valid}, 32'h0);
      check("arst_occ", {24'h0, bus.occ}, 32'h0);
      check("arst_out0", bus.OUT0, 32'h0);
      check("arst_out2", bus.OUT2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 2'b10, 32'h12345678, 4'b0000);
      tick();
      drive(1'b0, 2'b00, 32'h0, 4'b0000);
      check("post_out_valid", {28'h0, bus.out_valid}, 32'h4);
      check("post_out2", bus.OUT2, 32'h12345678);
      check("post_occ", {24'h0, bus.occ}, 32'h10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
